// File: rtl/core_mem.sv
// core_mem: single-cycle-latency tightly coupled memory shared by the
// instruction fetch (IFU) port and the load/store (LSU) port.
//
// After reset, a hardware clear sequence runs. It writes zero to every word,
// one word per cycle. The memory then serves both ports every cycle. Reads
// are write-first: a read returns the word as it stands after this cycle's
// LSU byte-strobe merge.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   ifu_addr   in   fetch byte address
//   ifu_data   out  registered fetch data
//   lsu_addr   in   load/store byte address
//   lsu_wdata  in   store data
//   lsu_strobe in   byte write enables (all zero = read only)
//   lsu_rdata  out  registered load data
//   init_done  out  high once the clear sequence has finished
//   ifu_err    out  one-cycle pulse for an invalid fetch address
//   lsu_err    out  one-cycle pulse for an invalid LSU address
module core_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DATA_BYTE  = 4,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic [DATA_WIDTH-1:0] ifu_data,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [DATA_BYTE-1:0]  lsu_strobe,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  init_done,
  output logic                  ifu_err,
  output logic                  lsu_err
);

  localparam int                    OFF_W    = $clog2(DATA_BYTE);
  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(DATA_BYTE - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] ifu_data_q, ifu_data_d;
  logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
  logic                  ifu_err_q, ifu_err_d;
  logic                  lsu_err_q, lsu_err_d;

  logic                  clear_en;
  logic                  ready;
  logic                  wr_en;

  // Address decode. The offset wraps modulo 2^ADDR_WIDTH, so addresses below
  // the base land far past the end of the array and decode as invalid.
  logic [ADDR_WIDTH-1:0] ifu_off, lsu_off, ifu_widx, lsu_widx;
  logic                  ifu_ok, lsu_ok;
  logic [IDX_W-1:0]      ifu_idx, lsu_idx;

  assign ifu_off  = ifu_addr - BASE_ADDR;
  assign lsu_off  = lsu_addr - BASE_ADDR;
  assign ifu_widx = ifu_off >> OFF_W;
  assign lsu_widx = lsu_off >> OFF_W;
  assign ifu_ok   = ((ifu_off & LSB_MASK) == '0) && (ifu_widx < DEPTH_A);
  assign lsu_ok   = ((lsu_off & LSB_MASK) == '0) && (lsu_widx < DEPTH_A);
  assign ifu_idx  = ifu_widx[IDX_W-1:0];
  assign lsu_idx  = lsu_widx[IDX_W-1:0];

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk the counter through every word, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: clearing in INIT, serving accesses in READY.
  always_comb begin
    clear_en = 1'b0;
    ready    = 1'b0;
    case (state_q)
      ST_INIT:  clear_en = rst_n;
      ST_READY: ready    = rst_n;
      default: begin
        clear_en = 1'b0;
        ready    = 1'b0;
      end
    endcase
  end

  // Byte-strobe merge of the addressed LSU word. With no strobes set, this is
  // just the stored word.
  logic [DATA_WIDTH-1:0] lsu_merged;
  always_comb begin
    lsu_merged = mem_q[lsu_idx];
    for (int b = 0; b < DATA_BYTE; b++) begin
      if (lsu_strobe[b]) begin
        lsu_merged[8*b +: 8] = lsu_wdata[8*b +: 8];
      end else begin
        lsu_merged[8*b +: 8] = mem_q[lsu_idx][8*b +: 8];
      end
    end
  end

  assign wr_en = ready && lsu_ok && (lsu_strobe != '0);

  // Read data selection (write-first) and error flags.
  always_comb begin
    ifu_data_d  = '0;
    lsu_rdata_d = '0;
    ifu_err_d   = 1'b0;
    lsu_err_d   = 1'b0;
    if (ready) begin
      if (lsu_ok) begin
        lsu_rdata_d = lsu_merged;
      end else begin
        lsu_err_d = 1'b1;
      end
      if (!ifu_ok) begin
        ifu_err_d = 1'b1;
      end else if (wr_en && (ifu_idx == lsu_idx)) begin
        ifu_data_d = lsu_merged;
      end else begin
        ifu_data_d = mem_q[ifu_idx];
      end
    end else begin
      ifu_data_d  = '0;
      lsu_rdata_d = '0;
    end
  end

  // Word array. It holds no reset value and is zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[lsu_idx] <= lsu_merged;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifu_data_q  <= '0;
      lsu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      ifu_data_q  <= ifu_data_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_err_q   <= ifu_err_d;
      lsu_err_q   <= lsu_err_d;
    end
  end

  assign ifu_data  = ifu_data_q;
  assign lsu_rdata = lsu_rdata_q;
  assign ifu_err   = ifu_err_q;
  assign lsu_err   = lsu_err_q;
  assign init_done = (state_q == ST_READY);

endmodule

// File: doc/core_mem.md
# core_mem

Single-cycle-latency tightly coupled memory that sits on the other end of the core's fetch and load/store ports. It serves instruction reads on the IFU port and reads/byte-strobed writes on the LSU port from one shared word array. After reset it runs a hardware clear sequence, then responds to both ports every cycle. It is instantiated next to `core_top` in the simulation top and is the memory model the core is verified against.

## Interface
- `ADDR_WIDTH`, default 32: byte address width, matches `cpu_define`.
- `DATA_WIDTH`, default 32: word width.
- `DATA_BYTE`, default 4: strobe width, equal to DATA_WIDTH/8.
- `DEPTH`, default 1024: number of words. Must be a power of two ≥ 2.
- `BASE_ADDR`, default 0: byte address of word 0. Must be DATA_BYTE-aligned.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `ifu_addr`  in  ADDR_WIDTH: fetch byte address, sampled every cycle.
- `ifu_data`  out  DATA_WIDTH: fetch read data, registered.
- `lsu_addr`  in  ADDR_WIDTH: load/store byte address, sampled every cycle.
- `lsu_wdata`  in  DATA_WIDTH: store data. Driven by the core's `lsu_data_o`.
- `lsu_strobe`  in  DATA_BYTE: byte write enables. Zero means the access is a read only.
- `lsu_rdata`  out  DATA_WIDTH: load read data, registered. Drives the core's `lsu_data_i`.
- `init_done`  out  1: high once the clear sequence has finished.
- `ifu_err`  out  1: one-cycle pulse for a bad fetch address.
- `lsu_err`  out  1: one-cycle pulse for a bad LSU address.

## Operation
- **Address decode, per port.** `off = addr - BASE_ADDR` is computed modulo 2^ADDR_WIDTH. `idx = off >> log2(DATA_BYTE)`.
  - The access is valid when `off[log2(DATA_BYTE)-1:0] == 0` and `idx < DEPTH`.
  - An address below BASE_ADDR wraps to a large offset and is therefore invalid.
- **State machine: INIT and READY.**
  - While `rst_n` is low: state becomes INIT and the clear counter becomes 0.
  - In INIT: write 0 to `mem[counter]` and increment the counter each cycle. When the counter equals DEPTH-1, move to READY on that edge.
  - READY holds until the next reset. A reset in the middle of INIT restarts the clear from word 0.
- **In INIT:**
  - All LSU writes are dropped.
  - `ifu_data` and `lsu_rdata` are registered as 0.
  - `ifu_err` and `lsu_err` stay 0.
- **Writes in READY.** For each byte b with `lsu_strobe[b]` set, `mem[idx]` byte b takes `lsu_wdata` byte b. Other bytes keep their value. An invalid address drops the write.
- **Reads in READY, write-first.**
  - The registered value is the word after this cycle's LSU strobe merge.
  - An LSU read-modify-write returns the merged word.
  - An IFU read of the same idx as a same-cycle LSU write also returns the merged word.
- **Invalid read.** The data register loads 0 and the port's err flag is high for the next cycle only.
- **Alignment.** There is no sub-word alignment handling. The LSU is responsible for positioning byte lanes and strobes.

## Timing
- **Reset values**, on the edge where `rst_n` is low:
  - `ifu_data` = 0, `lsu_rdata` = 0
  - `init_done` = 0
  - `ifu_err` = 0, `lsu_err` = 0
- **Clear duration.** INIT lasts exactly DEPTH cycles after `rst_n` rises. `init_done` is 1 from the edge that enters READY onward.
- **Read latency is 1.** An address presented in cycle N gives data (and err) visible in cycle N+1. Both ports accept a new address every cycle, with no stalls.
- **Write timing.** A write in cycle N is committed at the end of cycle N. Any read of that word issued in cycle N or later sees the new value.
- **Clear / first-access boundary.** A write in the same cycle as the final INIT edge is dropped. The first accepted write is in the first cycle where `init_done` is 1.

## Test plan
1. **Clear sequence.** DEPTH=16. Release reset, then hold `lsu_strobe`=4'hF with wdata 32'hDEADBEEF for 16 cycles.
   - `init_done` rises exactly 16 cycles after release.
   - A read of every word then returns 0.
2. **Byte strobes.** In READY:
   - Write 32'h11223344 with strobe 4'hF to BASE+8.
   - Next cycle, write 32'hAABBCCDD with strobe 4'b0101.
   - A read of BASE+8 returns 32'h11BB33DD, one cycle after the address is presented.
3. **Same-cycle collision.** In one cycle, LSU writes 32'h0000CAFE with strobe 4'b0011 to word 3, and IFU reads word 3 (previously 32'h12345678).
   - Next cycle, both `ifu_data` and `lsu_rdata` equal 32'h1234CAFE.
4. **Bad addresses.** DEPTH=16, BASE=32'h1000. Present, one per cycle:
   - `lsu_addr`=32'h1002 (misaligned)
   - 32'h1040 (past end)
   - 32'h0FFC (below base)
   - All with strobe 4'hF. Each gives `lsu_err`=1 for one cycle with `lsu_rdata`=0, and memory is unchanged.
   - `ifu_addr`=32'h1041 gives `ifu_err`=1.
5. **Reset mid-clear.** Assert `rst_n`=0 for 1 cycle at INIT count 7.
   - `init_done` stays 0, and the outputs are zeroed.
   - The clear restarts, and `init_done` rises DEPTH cycles after the second release.
6. **Back-to-back streaming.** IFU addresses BASE, +4, +8 … in consecutive cycles over preloaded words.
   - Each word appears exactly 1 cycle after its address, with no bubbles.
